// File: rtl/dmem_load_ctrl_pkg.sv
// Shared types and default control-byte values for the UART dmem loader.
package dmem_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ESC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } load_state_t;

  localparam logic [7:0] START_BYTE_DEF = 8'h0A;
  localparam logic [7:0] END_BYTE_DEF   = 8'h0B;
  localparam logic [7:0] ESC_BYTE_DEF   = 8'h1B;

endpackage

// File: rtl/dmem_load_ctrl_packer.sv
// Packs received bytes little-endian into 32-bit words; word_ready marks the
// byte that completes a word, with the full word presented combinationally.
module dmem_load_ctrl_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  lane,
  output logic [31:0] partial,
  output logic        word_ready,
  output logic [31:0] word
);

  always_comb begin
    word = partial;
    word[lane*8 +: 8] = byte_data;
  end

  assign word_ready = byte_valid && (lane == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane    <= 2'd0;
      partial <= 32'd0;
    end else if (clear) begin
      lane    <= 2'd0;
      partial <= 32'd0;
    end else if (byte_valid) begin
      // Completed words leave the accumulator zeroed so a later flush pads with 0.
      if (word_ready) begin
        lane    <= 2'd0;
        partial <= 32'd0;
      end else begin
        lane    <= lane + 2'd1;
        partial <= word;
      end
    end
  end

endmodule

// File: rtl/dmem_load_ctrl.sv
// UART download sequencer for dmem plus loader/CPU port arbitration.
// state | meaning
// LOAD  | accepting payload and control bytes, loader owns dmem
// ESC   | next byte is stored literally
// FLUSH | one-cycle write of the partial word
// RUN   | CPU owns dmem, only START is honoured
module dmem_load_ctrl
  import dmem_load_ctrl_pkg::*;
#(
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter logic [7:0] END_BYTE   = END_BYTE_DEF,
  parameter logic [7:0] ESC_BYTE   = ESC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [31:0]       cpu_data,
  input  logic              cpu_wren,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [31:0]       dmem_data,
  output logic              dmem_wren,
  output logic              cpu_run,
  output logic [ADDR_W:0]   load_words,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  load_state_t       state;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_wren;
  logic [1:0]        lane;
  logic [31:0]       partial;
  logic [31:0]       full_word;
  logic              word_ready;
  logic              is_ctrl;
  logic              byte_take;
  logic              start_hit;
  logic              end_hit;
  logic              flush_go;
  logic              commit;
  logic [31:0]       commit_word;

  assign is_ctrl   = (rx_data == START_BYTE) || (rx_data == END_BYTE) || (rx_data == ESC_BYTE);
  assign byte_take = rx_valid && (((state == ST_LOAD) && !is_ctrl) || (state == ST_ESC));
  assign start_hit = rx_valid && (rx_data == START_BYTE) &&
                     ((state == ST_LOAD) || (state == ST_RUN));
  assign end_hit   = rx_valid && (state == ST_LOAD) && (rx_data == END_BYTE);
  assign flush_go  = end_hit && (lane != 2'd0);
  assign commit    = word_ready || flush_go;
  assign commit_word = word_ready ? full_word : partial;

  dmem_load_ctrl_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_hit || end_hit),
    .byte_valid (byte_take),
    .byte_data  (rx_data),
    .lane       (lane),
    .partial    (partial),
    .word_ready (word_ready),
    .word       (full_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_LOAD;
      cpu_run    <= 1'b0;
      load_words <= '0;
      overflow   <= 1'b0;
      ld_wren    <= 1'b0;
      ld_addr    <= '0;
      ld_data    <= 32'd0;
    end else begin
      ld_wren <= 1'b0;
      // load_words doubles as the next word index; it stops at capacity.
      if (commit) begin
        if (load_words == CAPACITY) begin
          overflow <= 1'b1;
        end else begin
          ld_wren    <= 1'b1;
          ld_addr    <= load_words[ADDR_W-1:0];
          ld_data    <= commit_word;
          load_words <= load_words + 1'b1;
        end
      end
      if (start_hit) begin
        load_words <= '0;
        overflow   <= 1'b0;
      end
      case (state)
        ST_LOAD: begin
          if (end_hit) begin
            state   <= flush_go ? ST_FLUSH : ST_RUN;
            cpu_run <= !flush_go;
          end else if (rx_valid && (rx_data == ESC_BYTE)) begin
            state <= ST_ESC;
          end
        end
        ST_ESC: begin
          if (rx_valid) state <= ST_LOAD;
        end
        ST_FLUSH: begin
          state   <= ST_RUN;
          cpu_run <= 1'b1;
        end
        ST_RUN: begin
          if (start_hit) begin
            state   <= ST_LOAD;
            cpu_run <= 1'b0;
          end
        end
        default: begin
          state   <= ST_LOAD;
          cpu_run <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    if (state == ST_RUN) begin
      dmem_address = cpu_address;
      dmem_data    = cpu_data;
      dmem_wren    = cpu_wren;
    end else begin
      dmem_address = ld_addr;
      dmem_data    = ld_data;
      dmem_wren    = ld_wren;
    end
  end

endmodule

// File: tb/tb_dmem_load_ctrl.sv
// Directed bench for dmem_load_ctrl: a 12-bit-address instance and a
// 2-bit-address instance share stimulus; dmem writes are logged per instance.
module tb_dmem_load_ctrl;

  typedef struct packed {
    logic        run;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [11:0] cpu_address = '0;
  logic [31:0] cpu_data = '0;
  logic        cpu_wren = 1'b0;

  logic [11:0] dmem_address;
  logic [31:0] dmem_data;
  logic        dmem_wren;
  logic        cpu_run;
  logic [12:0] load_words;
  logic        overflow;

  logic [1:0]  s_dmem_address;
  logic [31:0] s_dmem_data;
  logic        s_dmem_wren;
  logic        s_cpu_run;
  logic [2:0]  s_load_words;
  logic        s_overflow;

  int vectors = 0;
  int miscompares = 0;
  wr_t q[$];
  wr_t qs[$];

  always #5 clk = ~clk;

  dmem_load_ctrl #(.ADDR_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
    .dmem_address(dmem_address), .dmem_data(dmem_data), .dmem_wren(dmem_wren),
    .cpu_run(cpu_run), .load_words(load_words), .overflow(overflow)
  );

  dmem_load_ctrl #(.ADDR_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_address(cpu_address[1:0]), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
    .dmem_address(s_dmem_address), .dmem_data(s_dmem_data), .dmem_wren(s_dmem_wren),
    .cpu_run(s_cpu_run), .load_words(s_load_words), .overflow(s_overflow)
  );

  always @(posedge clk) begin
    if (dmem_wren) q.push_back('{run: cpu_run, addr: dmem_address, data: dmem_data});
    if (s_dmem_wren) qs.push_back('{run: s_cpu_run, addr: {10'd0, s_dmem_address}, data: s_dmem_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_run", 64'(cpu_run), 64'd0);
    chk("rst_load_words", 64'(load_words), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_wren", 64'(dmem_wren), 64'd0);
    reset_n = 1'b1;
    tick();

    // Full word then END: one write, RUN one cycle after END.
    q.delete();
    send(8'h0A); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h0B);
    chk("t1_cpu_run", 64'(cpu_run), 64'd1);
    chk("t1_nwrites", 64'(q.size()), 64'd1);
    if (q.size() > 0) begin
      chk("t1_addr", 64'(q[0].addr), 64'd0);
      chk("t1_data", 64'(q[0].data), 64'h44332211);
    end
    chk("t1_load_words", 64'(load_words), 64'd1);

    // Partial word goes through FLUSH: RUN two cycles after END.
    q.delete();
    send(8'h0A); send(8'hAA); send(8'hBB); send(8'h0B);
    chk("t2_cpu_run_flush", 64'(cpu_run), 64'd0);
    tick();
    chk("t2_cpu_run", 64'(cpu_run), 64'd1);
    chk("t2_nwrites", 64'(q.size()), 64'd1);
    if (q.size() > 0) begin
      chk("t2_addr", 64'(q[0].addr), 64'd0);
      chk("t2_data", 64'(q[0].data), 64'h0000BBAA);
    end
    chk("t2_load_words", 64'(load_words), 64'd1);

    // Escaped control bytes become payload.
    q.delete();
    send(8'h0A); send(8'h1B); send(8'h0A); send(8'h1B); send(8'h0B);
    send(8'h1B); send(8'h1B); send(8'h01); send(8'h0B);
    chk("t3_cpu_run", 64'(cpu_run), 64'd1);
    chk("t3_nwrites", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("t3_data", 64'(q[0].data), 64'h011B0B0A);
    chk("t3_load_words", 64'(load_words), 64'd1);

    // CPU write in the START cycle commits; blocked afterwards.
    q.delete();
    cpu_address = 12'd5;
    cpu_data    = 32'hDEADBEEF;
    cpu_wren    = 1'b1;
    send(8'h0A);
    chk("t4_cpu_run", 64'(cpu_run), 64'd0);
    chk("t4_wren_blocked", 64'(dmem_wren), 64'd0);
    tick();
    cpu_wren = 1'b0;
    chk("t4_nwrites", 64'(q.size()), 64'd1);
    if (q.size() > 0) begin
      chk("t4_run_flag", 64'(q[0].run), 64'd1);
      chk("t4_addr", 64'(q[0].addr), 64'd5);
      chk("t4_data", 64'(q[0].data), 64'hDEADBEEF);
    end

    // Reset mid-word discards partial bytes.
    send(8'h55); send(8'h66);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_load_words", 64'(load_words), 64'd0);
    reset_n = 1'b1;
    q.delete();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick();
    chk("t6_nwrites", 64'(q.size()), 64'd1);
    if (q.size() > 0) begin
      chk("t6_addr", 64'(q[0].addr), 64'd0);
      chk("t6_data", 64'(q[0].data), 64'h04030201);
    end
    send(8'h0B);
    chk("t6_cpu_run", 64'(cpu_run), 64'd1);

    // Five words into a four-word memory.
    q.delete();
    qs.delete();
    send(8'h0A);
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i));
    send(8'h0B);
    chk("t5_s_nwrites", 64'(qs.size()), 64'd4);
    for (int i = 0; i < 4 && i < qs.size(); i++) begin
      logic [7:0] b0;
      b0 = 8'(8'h40 + 4 * i);
      chk($sformatf("t5_s_addr%0d", i), 64'(qs[i].addr), 64'(i));
      chk($sformatf("t5_s_data%0d", i), 64'(qs[i].data),
          64'({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}));
    end
    chk("t5_s_overflow", 64'(s_overflow), 64'd1);
    chk("t5_s_load_words", 64'(s_load_words), 64'd4);
    chk("t5_s_cpu_run", 64'(s_cpu_run), 64'd1);
    chk("t5_big_load_words", 64'(load_words), 64'd5);
    chk("t5_big_overflow", 64'(overflow), 64'd0);
    chk("t5_big_nwrites", 64'(q.size()), 64'd5);
    send(8'h0A);
    chk("t5_s_ovf_clr", 64'(s_overflow), 64'd0);
    chk("t5_s_lw_clr", 64'(s_load_words), 64'd0);
    chk("t5_s_cpu_run_clr", 64'(s_cpu_run), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
